// File: rtl/sobel_window_calc_if.sv
// Pixel-stream and result bundle for sobel_window_calc.
// The master drives the pixel stream and move direction; the slave returns results and status.
interface sobel_window_calc_if;
    logic       load_9;
    logic       pixel_valid;
    logic [7:0] pixel_in;
    logic [1:0] direction;
    logic [7:0] sobel_out;
    logic       sobel_valid;
    logic       window_full;
    logic       dir_err;

    // Handshake: pixel_in is taken at every rising edge where pixel_valid=1.
    // There is no back-pressure. sobel_valid is a 1-cycle pulse that qualifies sobel_out.
    modport master (
        output load_9, pixel_valid, pixel_in, direction,
        input  sobel_out, sobel_valid, window_full, dir_err
    );

    modport slave (
        input  load_9, pixel_valid, pixel_in, direction,
        output sobel_out, sobel_valid, window_full, dir_err
    );
endinterface

// File: rtl/sobel_window_calc.sv
// 3x3 window tracker and two-stage Sobel |Gx|+|Gy| pipeline fed by a serpentine pixel stream.
// Optional build macro SOBEL_THRESH_EN binarises the output against THRESHOLD.
module sobel_window_calc #(
    parameter logic [7:0] THRESHOLD = 8'd128
) (
    input  logic                  clk,
    input  logic                  n_reset,
    sobel_window_calc_if.slave    bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2,
        GROUP = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] s0_q, s0_d, s1_q, s1_d;
    logic       full_q, full_d;
    logic       err_q, err_d;
    logic       issue_q, issue_d;

    // Window flattened row-major: win[3*r + c] holds w[r][c].
    logic [7:0] win_q [9];
    logic [7:0] win_d [9];

    logic signed [10:0] gx_q, gx_d, gy_q, gy_d;
    logic               v1_q;
    logic [7:0]         out_q, out_d;
    logic               valid_q;

    logic [10:0] abs_x, abs_y;
    logic [11:0] mag;

    logic unused_thr;
    assign unused_thr = ^THRESHOLD;

    always_ff @(posedge clk) begin
        if (n_reset) begin
            state_q <= EMPTY;
            cnt_q   <= 4'd0;
            s0_q    <= 8'd0;
            s1_q    <= 8'd0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            issue_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            full_q  <= full_d;
            err_q   <= err_d;
            issue_q <= issue_d;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        full_d  = full_q;
        err_d   = err_q;
        issue_d = 1'b0;
        for (int i = 0; i < 9; i++) begin
            win_d[i] = win_q[i];
        end

        if (bus.load_9) begin
            state_d = FILL;
            cnt_d   = 4'd0;
            full_d  = 1'b0;
            s0_d    = 8'd0;
            s1_d    = 8'd0;
            if (bus.pixel_valid) begin
                win_d[0] = bus.pixel_in;
                cnt_d    = 4'd1;
            end
        end else if (bus.pixel_valid) begin
            case (state_q)
                FILL: begin
                    win_d[cnt_q] = bus.pixel_in;
                    if (cnt_q == 4'd8) begin
                        state_d = READY;
                        cnt_d   = 4'd0;
                        full_d  = 1'b1;
                        issue_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                READY: begin
                    s0_d    = bus.pixel_in;
                    cnt_d   = 4'd1;
                    state_d = GROUP;
                end
                GROUP: begin
                    if (cnt_q == 4'd1) begin
                        s1_d  = bus.pixel_in;
                        cnt_d = 4'd2;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = READY;
                        // Direction only matters on the pixel that completes the group.
                        case (bus.direction)
                            2'b01: begin
                                win_d[0] = win_q[1]; win_d[1] = win_q[2]; win_d[2] = s0_q;
                                win_d[3] = win_q[4]; win_d[4] = win_q[5]; win_d[5] = s1_q;
                                win_d[6] = win_q[7]; win_d[7] = win_q[8]; win_d[8] = bus.pixel_in;
                                issue_d  = 1'b1;
                            end
                            2'b10: begin
                                win_d[2] = win_q[1]; win_d[1] = win_q[0]; win_d[0] = s0_q;
                                win_d[5] = win_q[4]; win_d[4] = win_q[3]; win_d[3] = s1_q;
                                win_d[8] = win_q[7]; win_d[7] = win_q[6]; win_d[6] = bus.pixel_in;
                                issue_d  = 1'b1;
                            end
                            2'b11: begin
                                for (int i = 0; i < 6; i++) begin
                                    win_d[i] = win_q[i+3];
                                end
                                win_d[6] = s0_q;
                                win_d[7] = s1_q;
                                win_d[8] = bus.pixel_in;
                                issue_d  = 1'b1;
                            end
                            default: begin
                                err_d = 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

    function automatic logic signed [10:0] px(input logic [7:0] v);
        return $signed({3'b000, v});
    endfunction

    always_comb begin
        gx_d = (px(win_q[2]) + px(win_q[5]) + px(win_q[5]) + px(win_q[8]))
             - (px(win_q[0]) + px(win_q[3]) + px(win_q[3]) + px(win_q[6]));
        gy_d = (px(win_q[6]) + px(win_q[7]) + px(win_q[7]) + px(win_q[8]))
             - (px(win_q[0]) + px(win_q[1]) + px(win_q[1]) + px(win_q[2]));
    end

    always_comb begin
        abs_x = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
        abs_y = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
        mag   = {1'b0, abs_x} + {1'b0, abs_y};
`ifdef SOBEL_THRESH_EN
        out_d = (mag >= {4'd0, THRESHOLD}) ? 8'd255 : 8'd0;
`else
        out_d = (mag[11:8] != 4'd0) ? 8'd255 : mag[7:0];
`endif
    end

    // The pipeline reads the window one edge after the update, before any later write lands.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            gx_q    <= 11'sd0;
            gy_q    <= 11'sd0;
            v1_q    <= 1'b0;
            out_q   <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            v1_q    <= issue_q;
            valid_q <= v1_q;
            if (v1_q) begin
                out_q <= out_d;
            end
        end
    end

    assign bus.sobel_out   = out_q;
    assign bus.sobel_valid = valid_q;
    assign bus.window_full = full_q;
    assign bus.dir_err     = err_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_sobel_window_calc.sv
// Directed bench for sobel_window_calc: fills, column/row moves, invalid direction, reset mid-group.
// Expected magnitudes are hand-computed; SOBEL_THRESH_EN switches them to 0/255.
module tb_sobel_window_calc;
    localparam int THRESHOLD = 128;

    logic       clk;
    logic       n_reset;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_fail;

    sobel_window_calc_if bus_if ();

    sobel_window_calc #(.THRESHOLD(8'(THRESHOLD))) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .bus         (bus_if),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ex(input int mag);
`ifdef SOBEL_THRESH_EN
        return (mag >= THRESHOLD) ? 8'd255 : 8'd0;
`else
        return (mag > 255) ? 8'd255 : mag[7:0];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic pv, input logic [7:0] p, input logic [1:0] d);
        @(negedge clk);
        bus_if.load_9      = ld;
        bus_if.pixel_valid = pv;
        bus_if.pixel_in    = p;
        bus_if.direction   = d;
        @(posedge clk);
        #1;
        bus_if.load_9      = 1'b0;
        bus_if.pixel_valid = 1'b0;
    endtask

    task automatic fill(input logic [7:0] v [9], input logic same_cycle);
        if (same_cycle) begin
            drive(1'b1, 1'b1, v[0], 2'b01);
            for (int i = 1; i < 9; i++) drive(1'b0, 1'b1, v[i], 2'b01);
        end else begin
            drive(1'b1, 1'b0, 8'd0, 2'b01);
            for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, v[i], 2'b01);
        end
    endtask

    task automatic group(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [1:0] d);
        drive(1'b0, 1'b1, a, d);
        drive(1'b0, 1'b1, b, d);
        drive(1'b0, 1'b1, c, d);
    endtask

    // Called just after the completing edge N: result must pulse exactly after edge N+2.
    task automatic expect_result(input string tag, input logic [7:0] exp);
        check({tag, "_v_n0"}, 32'(bus_if.sobel_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_v_n1"}, 32'(bus_if.sobel_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_v_n2"}, 32'(bus_if.sobel_valid), 32'd1);
        check({tag, "_out"}, 32'(bus_if.sobel_out), 32'(exp));
        @(posedge clk); #1;
        check({tag, "_v_n3"}, 32'(bus_if.sobel_valid), 32'd0);
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        n_reset            = 1'b1;
        bus_if.load_9      = 1'b0;
        bus_if.pixel_valid = 1'b0;
        bus_if.pixel_in    = 8'd0;
        bus_if.direction   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 32'(bus_if.sobel_out), 32'd0);
        check("rst_valid", 32'(bus_if.sobel_valid), 32'd0);
        check("rst_full", 32'(bus_if.window_full), 32'd0);
        check("rst_err", 32'(bus_if.dir_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        n_reset = 1'b0;

        // Flat field of 50 gives zero gradient.
        drive(1'b1, 1'b0, 8'd0, 2'b01);
        check("t1_full_loading", 32'(bus_if.window_full), 32'd0);
        check("t1_state_fill", 32'(dbg_state), 32'd1);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'd50, 2'b01);
        check("t1_full_before_9th", 32'(bus_if.window_full), 32'd0);
        drive(1'b0, 1'b1, 8'd50, 2'b01);
        check("t1_full", 32'(bus_if.window_full), 32'd1);
        check("t1_state_ready", 32'(dbg_state), 32'd2);
        expect_result("t1", ex(0));

        // Columns 10/20/30, then right and left moves.
        fill('{8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30}, 1'b1);
        expect_result("t2_fill", ex(80));
        group(8'd40, 8'd40, 8'd40, 2'b01);
        expect_result("t2_right", ex(80));
        group(8'd0, 8'd0, 8'd0, 2'b10);
        expect_result("t2_left", ex(120));

        // Vertical edge saturates, then a row move keeps it saturated.
        fill('{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255}, 1'b0);
        expect_result("t3_fill", ex(1020));
        group(8'd255, 8'd255, 8'd255, 2'b11);
        expect_result("t3_row", ex(1020));

        // Non-saturating row move: rows 0/10/20 then 10/20/40.
        fill('{8'd0, 8'd0, 8'd0, 8'd10, 8'd10, 8'd10, 8'd20, 8'd20, 8'd20}, 1'b0);
        expect_result("t4_fill", ex(80));
        group(8'd40, 8'd40, 8'd40, 2'b11);
        expect_result("t4_row", ex(120));

        // Invalid direction leaves the window alone; a later right move of zeros gives |-90|+90.
        group(8'd99, 8'd99, 8'd99, 2'b00);
        for (int i = 0; i < 4; i++) begin
            check("t5_no_valid", 32'(bus_if.sobel_valid), 32'd0);
            @(posedge clk); #1;
        end
        check("t5_err", 32'(bus_if.dir_err), 32'd1);
        check("t5_state_ready", 32'(dbg_state), 32'd2);
        group(8'd0, 8'd0, 8'd0, 2'b01);
        expect_result("t5_after", ex(180));
        check("t5_err_sticky", 32'(bus_if.dir_err), 32'd1);

        // Step edge 10,10,140 then a left move of 7s giving columns 7/10/10.
        fill('{8'd10, 8'd10, 8'd140, 8'd10, 8'd10, 8'd140, 8'd10, 8'd10, 8'd140}, 1'b1);
        expect_result("t6_step", ex(520));
        group(8'd7, 8'd7, 8'd7, 2'b10);
        expect_result("t6_left", ex(12));

        // load_9 right after a completing pixel must not flush the pending result.
        fill('{8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30}, 1'b1);
        drive(1'b1, 1'b0, 8'd0, 2'b01);
        check("t7_full_cleared", 32'(bus_if.window_full), 32'd0);
        check("t7_v_n1", 32'(bus_if.sobel_valid), 32'd0);
        @(posedge clk); #1;
        check("t7_v_n2", 32'(bus_if.sobel_valid), 32'd1);
        check("t7_out", 32'(bus_if.sobel_out), 32'(ex(80)));
        check("t7_state_fill", 32'(dbg_state), 32'd1);

        // Reset in the middle of a group clears everything, including dir_err.
        fill('{8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50}, 1'b0);
        expect_result("t8_fill", ex(0));
        drive(1'b0, 1'b1, 8'd200, 2'b01);
        drive(1'b0, 1'b1, 8'd200, 2'b01);
        check("t8_state_group", 32'(dbg_state), 32'd3);
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk); #1;
        check("t8_rst_out", 32'(bus_if.sobel_out), 32'd0);
        check("t8_rst_valid", 32'(bus_if.sobel_valid), 32'd0);
        check("t8_rst_full", 32'(bus_if.window_full), 32'd0);
        check("t8_rst_err", 32'(bus_if.dir_err), 32'd0);
        check("t8_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        n_reset = 1'b0;
        group(8'd200, 8'd0, 8'd200, 2'b01);
        for (int i = 0; i < 4; i++) begin
            check("t8_empty_no_valid", 32'(bus_if.sobel_valid), 32'd0);
            @(posedge clk); #1;
        end
        check("t8_empty_state", 32'(dbg_state), 32'd0);
        check("t8_empty_full", 32'(bus_if.window_full), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_window_calc.md
# sobel_window_calc

Consumes the pixel stream returned from image memory at the addresses produced by the serpentine address generator. Keeps a 3x3 pixel window up to date:
- Fills it with the initial 9-pixel read.
- Shifts it by one column or one row for every 3-pixel incremental read, according to the move direction.

After every window update it computes the Sobel gradient magnitude |Gx|+|Gy|, saturated to 8 bits, and hands that result to the write path.

## Interface
Parameters:
- THRESHOLD, default 8'd128: binarisation level, used only when SOBEL_THRESH_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- n_reset  in  1  synchronous, active-high reset: 1 at a rising clk edge resets the block.
- load_9  in  1  1-cycle pulse starting a 9-pixel initial fill.
- pixel_valid  in  1  pixel_in is valid this cycle.
- pixel_in  in  8  unsigned pixel from memory.
- direction  in  2  move direction:
  - 01: right, new right column, top to bottom.
  - 10: left, new left column, top to bottom.
  - 11: next row, new bottom row, left to right.
  - 00: invalid.
- sobel_out  out  8  gradient magnitude, or 0/255 when thresholded.
- sobel_valid  out  1  1-cycle pulse: sobel_out is valid.
- window_full  out  1  window holds valid data.
- dir_err  out  1  sticky: a 3-pixel group completed with direction 00.

## Operation
- Window registers: w[r][c], r,c in 0..2, where r0 is the top row and c0 is the left column. Staging registers: s0..s2. A 4-bit pixel counter cnt.
- States:
  - EMPTY (reset state).
  - FILL: accepting the 9 initial pixels.
  - READY: window full, waiting for the next group.
  - GROUP: collecting 3 incremental pixels.
- Transitions:
  - load_9 from any state → FILL, with cnt=0, window_full=0, staging discarded.
  - A pixel_valid in the same cycle as load_9 is accepted as fill pixel 0.
  - FILL: each accepted pixel is written row-major into w[cnt/3][cnt%3]. The 9th pixel (cnt=8) → READY, window_full=1, compute issued.
  - READY: pixel_valid → stored in s0, cnt=1 → GROUP.
  - GROUP: pixels are stored in s1, then s2. On the 3rd pixel, direction is sampled in that same cycle:
    - 01: columns shift left, c0←c1, c1←c2; new c2 rows 0..2 = s0, s1, pixel_in.
    - 10: columns shift right, c2←c1, c1←c0; new c0 rows 0..2 = s0, s1, pixel_in.
    - 11: rows shift up, r0←r1, r1←r2; new r2 cols 0..2 = s0, s1, pixel_in.
    - 00: window unchanged, no compute issued, dir_err set.
    - In every case the state returns to READY.
  - EMPTY: pixel_valid is ignored.
- Arithmetic:
  - Gx = (w02+2w12+w22) − (w00+2w10+w20).
  - Gy = (w20+2w21+w22) − (w00+2w01+w02).
  - Both are computed as 11-bit signed values (range ±1020).
  - mag = |Gx|+|Gy|, 12-bit unsigned (max 2040). sobel_out = min(mag, 255).
- Reset (at any point, mid-group included) clears:
  - state → EMPTY; cnt, staging, window → 0.
  - window_full=0, dir_err=0.
  - sobel_out=0, sobel_valid=0; all pipeline valid bits cleared.
- dir_err is cleared only by reset.

## Timing
- A pixel is accepted at a rising edge where pixel_valid=1.
- A window update takes place at the same edge as the completing pixel (the 9th fill pixel or the 3rd group pixel), edge N.
- Pipeline:
  - Stage 1 registers Gx and Gy at N+1.
  - Stage 2 registers sobel_out and sobel_valid at N+2.
- Latency is 2 cycles from the completing pixel to sobel_valid.
- The pipeline is fully pipelined and never stalls. Groups may arrive back-to-back, one pixel per cycle, giving at most one result per 3 cycles.
- A load_9 does not flush results already in the pipeline; they still emerge at their scheduled cycle.

## Configuration
- SOBEL_THRESH_EN:
  - Defined: stage 2 outputs 8'd255 if mag ≥ THRESHOLD, else 8'd0.
  - Undefined: stage 2 outputs saturated mag, and THRESHOLD is unused.
- Latency is identical in both builds.

## Test plan
- Reset, then load_9 + 9 pixels all equal to 50 → window_full=1; sobel_out=0 with sobel_valid exactly 2 cycles after the 9th pixel.
- Fill with rows {10,20,30}×3 → 80. Then a right group (dir 01) of 40,40,40 → window cols 20/30/40 → 80. Then a left group (dir 10) of 0,0,0 → cols 0/20/30 → 120.
- Fill with rows r0=0, r1=0, r2=255 → Gy=1020 → sobel_out=255 (saturation). Then a row group (dir 11) of 255,255,255 → rows 0/255/255 → 255.
- Group with direction 00 → window unchanged, no sobel_valid, dir_err=1 until the next reset.
- Assert n_reset after 2 pixels of a group → all outputs 0, state EMPTY. Subsequent pixel_valid without load_9 → no sobel_valid.
- With SOBEL_THRESH_EN and THRESHOLD=128:
  - window giving mag=80 → sobel_out=0.
  - window giving mag=120 → sobel_out=0.
  - 10-col/140-col step (cols 10,10,140) → mag=520 → sobel_out=255.
